// File: rtl/l2_arbiter.sv
// l2_arbiter: two-requester arbiter sharing one downstream cacheline port
// between the L1 I-cache (read-only fills) and the L1 D-cache
// (fills and writebacks).
//
// The arbiter adds one cycle per transaction: requests are arbitrated in
// IDLE and the winner is then served. While a side is being served, its
// request and the downstream response pass straight through
// combinationally. Every transaction ends with one IDLE cycle, so a
// requester always sees its resp drop before it can be granted again.
//
// Build option:
//   L2_ARBITER_RR_EN  When defined, simultaneous requests are resolved
//                     round-robin using a 1-bit pointer. The pointer points
//                     at D after reset. After every grant it moves to the
//                     side that was not granted. When undefined, D always
//                     wins simultaneous requests and there is no pointer.
module l2_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  // I-side (line fills only)
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,

  // D-side (fills and writebacks)
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,

  // Shared downstream port
  output logic                  m_read,
  output logic                  m_write,
  output logic [ADDR_WIDTH-1:0] m_address,
  output logic [LINE_WIDTH-1:0] m_wdata,
  input  logic [LINE_WIDTH-1:0] m_rdata,
  input  logic                  m_resp,

  // Current owner, for performance counters
  output logic                  grant_i,
  output logic                  grant_d
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic d_req;
  logic i_req;
  logic pick_d;

`ifdef L2_ARBITER_RR_EN
  // 1: D has priority on the next contested arbitration, 0: I has priority
  logic rr_d_q, rr_d_d;
`endif

  // Arbitration decision for the current IDLE cycle
  always_comb begin
    d_req = d_read | d_write;
    i_req = i_read;
`ifdef L2_ARBITER_RR_EN
    pick_d = d_req & (~i_req | rr_d_q);
`else
    pick_d = d_req;
`endif
  end

  // Next-state logic: arbitrate in IDLE; leave SERVE only on m_resp
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d = SERVE_D;
        end else if (i_req) begin
          state_d = SERVE_I;
        end
      end
      SERVE_I: begin
        if (m_resp) begin
          state_d = IDLE;
        end
      end
      SERVE_D: begin
        if (m_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef L2_ARBITER_RR_EN
  // Pointer update: after any grant, point at the side that was not granted
  always_comb begin
    rr_d_d = rr_d_q;
    if (state_q == IDLE) begin
      if (pick_d) begin
        rr_d_d = 1'b0;
      end else if (i_req) begin
        rr_d_d = 1'b1;
      end
    end
  end
`endif

  // State register; a reset abandons any in-flight downstream transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
`ifdef L2_ARBITER_RR_EN
      rr_d_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
`ifdef L2_ARBITER_RR_EN
      rr_d_q  <= rr_d_d;
`endif
    end
  end

  // Output routing: the served side drives the downstream port and receives
  // its data and strobe. The side that is not served sees all zeros.
  // A D request with both read and write set is issued as a write.
  // The resp strobes are masked during a reset cycle, so a downstream
  // response that lands while reset is asserted is dropped.
  always_comb begin
    m_read    = 1'b0;
    m_write   = 1'b0;
    m_address = '0;
    m_wdata   = '0;
    i_rdata   = '0;
    i_resp    = 1'b0;
    d_rdata   = '0;
    d_resp    = 1'b0;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    unique case (state_q)
      SERVE_I: begin
        grant_i   = 1'b1;
        m_read    = i_read;
        m_address = i_address;
        i_rdata   = m_rdata;
        i_resp    = m_resp & ~rst;
      end
      SERVE_D: begin
        grant_d   = 1'b1;
        m_write   = d_write;
        m_read    = d_read & ~d_write;
        m_address = d_address;
        m_wdata   = d_wdata;
        d_rdata   = m_rdata;
        d_resp    = m_resp & ~rst;
      end
      default: begin
      end
    endcase
  end

endmodule
